// File: rtl/sdram_wb_bridge.sv
// Wishbone-style bus to SDRAM controller bridge.
// Latches one bus request and issues it to the controller as a write or read request.
// A wait counter ends a request that the controller never answers and sets a sticky error flag.
module sdram_wb_bridge #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk_p,
    input  logic        sdram_reset,
    input  logic        sdram_stb,
    input  logic        sdram_we,
    input  logic [1:0]  sdram_sel,
    input  logic [21:1] sdram_adr,
    input  logic [15:0] sdram_out,
    output logic [15:0] sdram_dat,
    output logic        sdram_ack,
    input  logic        sdram_ready,
    output logic        sdr_wr_req,
    output logic        sdr_rd_req,
    input  logic        sdr_wr_ack,
    input  logic        sdr_rd_ack,
    output logic [22:0] sdr_addr,
    output logic [15:0] sdr_wdata,
    input  logic [15:0] sdr_rdata,
    output logic        dm_h,
    output logic        dm_l,
    output logic        tmo_err
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_ACK
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_wr_req;
    logic          r_rd_req;
    logic [15:0]   r_dat;
    logic          r_dm_h;
    logic          r_dm_l;
    logic [21:1]   r_addr;
    logic [15:0]   r_wdata;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_inc;
    logic          r_tmo;
    logic          r_armed;
    logic          w_latch;
    logic          w_cap;
    logic          w_tmo_hit;

    assign w_cnt_inc  = r_cnt + 1'b1;

    assign sdram_dat  = r_dat;
    assign sdram_ack  = sdram_stb && (r_state == S_ACK);
    assign sdr_wr_req = r_wr_req;
    assign sdr_rd_req = r_rd_req;
    assign sdr_addr   = {2'b00, r_addr};
    assign sdr_wdata  = r_wdata;
    assign dm_h       = r_dm_h;
    assign dm_l       = r_dm_l;
    assign tmo_err    = r_tmo;

    // Next-state decode; a controller ack takes priority over a coincident timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_cap       = 1'b0;
        w_tmo_hit   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (sdram_stb && sdram_ready && r_armed) begin
                    w_latch     = 1'b1;
                    w_state_nxt = sdram_we ? S_WR : S_RD;
                end
            end
            S_WR: begin
                if (sdr_wr_ack) begin
                    w_state_nxt = S_ACK;
                end else if (w_cnt_inc == CW'(TIMEOUT)) begin
                    w_state_nxt = S_ACK;
                    w_tmo_hit   = 1'b1;
                end
            end
            S_RD: begin
                if (sdr_rd_ack) begin
                    w_state_nxt = S_ACK;
                    w_cap       = 1'b1;
                end else if (w_cnt_inc == CW'(TIMEOUT)) begin
                    w_state_nxt = S_ACK;
                    w_tmo_hit   = 1'b1;
                end
            end
            S_ACK: begin
                if (!sdram_stb) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register, registered requests, latched request fields and read data.
    // r_armed only sets once stb is seen low, so a strobe held high across reset cannot start a transfer.
    always_ff @(posedge clk_p or posedge sdram_reset) begin
        if (sdram_reset) begin
            r_state  <= S_IDLE;
            r_wr_req <= 1'b0;
            r_rd_req <= 1'b0;
            r_dat    <= '0;
            r_dm_h   <= 1'b0;
            r_dm_l   <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_cnt    <= '0;
            r_tmo    <= 1'b0;
            r_armed  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_wr_req <= (w_state_nxt == S_WR);
            r_rd_req <= (w_state_nxt == S_RD);
            if (!sdram_stb) begin
                r_armed <= 1'b1;
            end else if (w_latch) begin
                r_armed <= 1'b0;
            end
            if (w_latch) begin
                r_addr  <= sdram_adr;
                r_wdata <= sdram_out;
                r_dm_h  <= sdram_we & ~sdram_sel[1];
                r_dm_l  <= sdram_we & ~sdram_sel[0];
                r_cnt   <= '0;
            end else if (r_state == S_WR || r_state == S_RD) begin
                r_cnt <= w_cnt_inc;
            end
            if (w_cap) begin
                r_dat <= sdr_rdata;
            end
            if (w_tmo_hit) begin
                r_tmo <= 1'b1;
                if (r_state == S_RD) begin
                    r_dat <= 16'hFFFF;
                end
            end
        end
    end

endmodule

// File: tb/tb_sdram_wb_bridge.sv
// Scoreboard bench for sdram_wb_bridge: stimulus pushes the expected ack-time view,
// a negedge monitor pops and compares when sdram_ack rises.
module tb_sdram_wb_bridge;

    logic        clk_p = 1'b0;
    logic        sdram_reset;
    logic        sdram_stb;
    logic        sdram_we;
    logic [1:0]  sdram_sel;
    logic [21:1] sdram_adr;
    logic [15:0] sdram_out;
    logic [15:0] sdram_dat;
    logic        sdram_ack;
    logic        sdram_ready;
    logic        sdr_wr_req;
    logic        sdr_rd_req;
    logic        sdr_wr_ack;
    logic        sdr_rd_ack;
    logic [22:0] sdr_addr;
    logic [15:0] sdr_wdata;
    logic [15:0] sdr_rdata;
    logic        dm_h;
    logic        dm_l;
    logic        tmo_err;

    sdram_wb_bridge #(.TIMEOUT(8)) dut (
        .clk_p      (clk_p),
        .sdram_reset(sdram_reset),
        .sdram_stb  (sdram_stb),
        .sdram_we   (sdram_we),
        .sdram_sel  (sdram_sel),
        .sdram_adr  (sdram_adr),
        .sdram_out  (sdram_out),
        .sdram_dat  (sdram_dat),
        .sdram_ack  (sdram_ack),
        .sdram_ready(sdram_ready),
        .sdr_wr_req (sdr_wr_req),
        .sdr_rd_req (sdr_rd_req),
        .sdr_wr_ack (sdr_wr_ack),
        .sdr_rd_ack (sdr_rd_ack),
        .sdr_addr   (sdr_addr),
        .sdr_wdata  (sdr_wdata),
        .sdr_rdata  (sdr_rdata),
        .dm_h       (dm_h),
        .dm_l       (dm_l),
        .tmo_err    (tmo_err)
    );

    always #5 clk_p = ~clk_p;

    typedef struct {
        logic        rd;
        logic [22:0] addr;
        logic [15:0] data;
        logic        dmh;
        logic        dml;
        logic        tmo;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   n_wr = 0;
    int   n_rd = 0;
    logic prev_ack = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_p);
        #1;
    endtask

    // Request-cycle counters, sampled away from the active edge
    always @(negedge clk_p) begin
        if (sdr_wr_req) n_wr++;
        if (sdr_rd_req) n_rd++;
    end

    // Monitor: on each rising sdram_ack, pop one expectation and compare
    always @(negedge clk_p) begin
        exp_t e;
        if (sdram_reset) begin
            prev_ack = 1'b0;
        end else begin
            if (sdram_ack && !prev_ack) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: got ack=1 expected none at %0t", $time);
                end else begin
                    e = sb.pop_front();
                    chk("ack_addr", sdr_addr, e.addr);
                    if (e.rd) chk("ack_rdata", sdram_dat, e.data);
                    else      chk("ack_wdata", sdr_wdata, e.data);
                    chk("ack_dm_h", dm_h, e.dmh);
                    chk("ack_dm_l", dm_l, e.dml);
                    chk("ack_tmo", tmo_err, e.tmo);
                end
            end
            prev_ack = sdram_ack;
        end
    end

    task automatic wait_ack();
        bit seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (sdram_ack) begin
                seen = 1;
                break;
            end
            tick();
        end
        if (!seen) chk("ack_timeout", 0, 1);
    endtask

    // delay = request cycles before the controller ack (<=0: controller stays silent)
    task automatic run_txn(input logic we, input logic [21:1] adr, input logic [15:0] wd,
                           input logic [1:0] sel, input int delay, input logic [15:0] rdv,
                           input logic [15:0] exp_dat, input logic [1:0] exp_dm,
                           input logic exp_tmo, input int exp_reqs, input int hold_ready);
        exp_t e;
        n_wr = 0;
        n_rd = 0;
        sdram_we  = we;
        sdram_adr = adr;
        sdram_out = wd;
        sdram_sel = sel;
        sdram_stb = 1'b1;
        if (hold_ready > 0) begin
            sdram_ready = 1'b0;
            repeat (hold_ready) tick();
            chk("no_req_unready", n_wr + n_rd, 0);
            sdram_ready = 1'b1;
        end
        e.rd   = ~we;
        e.addr = {2'b00, adr};
        e.data = exp_dat;
        e.dmh  = exp_dm[1];
        e.dml  = exp_dm[0];
        e.tmo  = exp_tmo;
        sb.push_back(e);
        tick();
        chk("req_first_cycle", we ? sdr_wr_req : sdr_rd_req, 1);
        if (delay > 0) begin
            repeat (delay - 1) tick();
            if (we) sdr_wr_ack = 1'b1;
            else begin
                sdr_rd_ack = 1'b1;
                sdr_rdata  = rdv;
            end
            tick();
            sdr_wr_ack = 1'b0;
            sdr_rd_ack = 1'b0;
            sdr_rdata  = 16'hDEAD;
            chk("ack_latency", sdram_ack, 1);
        end
        wait_ack();
        chk("req_cycles", we ? n_wr : n_rd, exp_reqs);
        sdram_adr = ~adr;
        sdram_out = ~wd;
        sdram_sel = ~sel;
        sdram_we  = ~we;
        tick();
        tick();
        chk("addr_hold", sdr_addr, {2'b00, adr});
        chk("ack_held", sdram_ack, 1);
        sdram_stb = 1'b0;
        tick();
        chk("ack_drop", sdram_ack, 0);
        chk("req_idle", sdr_wr_req | sdr_rd_req, 0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sdram_reset = 1'b1;
        sdram_stb   = 1'b0;
        sdram_we    = 1'b0;
        sdram_sel   = 2'b00;
        sdram_adr   = '0;
        sdram_out   = '0;
        sdram_ready = 1'b1;
        sdr_wr_ack  = 1'b0;
        sdr_rd_ack  = 1'b0;
        sdr_rdata   = '0;
        #3;
        chk("rst_wr_req", sdr_wr_req, 0);
        chk("rst_rd_req", sdr_rd_req, 0);
        chk("rst_ack", sdram_ack, 0);
        chk("rst_dat", sdram_dat, 0);
        chk("rst_addr", sdr_addr, 0);
        chk("rst_tmo", tmo_err, 0);
        tick();
        sdram_reset = 1'b0;
        tick();
        tick();

        // write, ack after 3 request cycles
        run_txn(1'b1, 21'h012345, 16'hA55A, 2'b01, 3, 16'h0000, 16'hA55A, 2'b10, 1'b0, 3, 0);
        // read, minimum latency, top address
        run_txn(1'b0, 21'h1FFFFF, 16'h0000, 2'b11, 1, 16'h1234, 16'h1234, 2'b00, 1'b0, 1, 0);
        // write high byte only
        run_txn(1'b1, 21'h000000, 16'h0F0F, 2'b10, 2, 16'h0000, 16'h0F0F, 2'b01, 1'b0, 2, 0);
        // controller not ready for 50 cycles
        run_txn(1'b0, 21'h00AAAA, 16'h0000, 2'b11, 2, 16'h4321, 16'h4321, 2'b00, 1'b0, 2, 50);
        // ack coincides with timeout: ack wins
        run_txn(1'b0, 21'h055555, 16'h0000, 2'b11, 8, 16'hBEEF, 16'hBEEF, 2'b00, 1'b0, 8, 0);
        // silent controller: timeout
        run_txn(1'b0, 21'h0FF00F, 16'h0000, 2'b11, 0, 16'h0000, 16'hFFFF, 2'b00, 1'b1, 8, 0);

        // stb drops during RD, controller completes later
        n_rd = 0;
        sdram_we  = 1'b0;
        sdram_adr = 21'h000100;
        sdram_sel = 2'b11;
        sdram_stb = 1'b1;
        tick();
        tick();
        sdram_stb = 1'b0;
        tick();
        sdr_rd_ack = 1'b1;
        sdr_rdata  = 16'h5AA5;
        tick();
        sdr_rd_ack = 1'b0;
        sdr_rdata  = 16'hDEAD;
        chk("abort_no_ack", sdram_ack, 0);
        chk("abort_dat", sdram_dat, 16'h5AA5);
        chk("abort_req_drop", sdr_rd_req, 0);
        chk("abort_req_cycles", n_rd, 3);
        tick();
        run_txn(1'b1, 21'h111111, 16'hCAFE, 2'b11, 1, 16'h0000, 16'hCAFE, 2'b00, 1'b1, 1, 0);

        // stray controller acks in IDLE are ignored
        n_wr = 0;
        n_rd = 0;
        sdr_wr_ack = 1'b1;
        sdr_rd_ack = 1'b1;
        sdr_rdata  = 16'h7777;
        tick();
        sdr_wr_ack = 1'b0;
        sdr_rd_ack = 1'b0;
        tick();
        chk("stray_dat", sdram_dat, 16'h5AA5);
        chk("stray_req", n_wr + n_rd, 0);

        // reset in the middle of a write
        sdram_we  = 1'b1;
        sdram_adr = 21'h0ABCDE;
        sdram_out = 16'h1357;
        sdram_sel = 2'b11;
        sdram_stb = 1'b1;
        tick();
        tick();
        chk("wr_before_rst", sdr_wr_req, 1);
        sdram_reset = 1'b1;
        #1;
        chk("mid_rst_wr_req", sdr_wr_req, 0);
        chk("mid_rst_dat", sdram_dat, 0);
        chk("mid_rst_dm", {dm_h, dm_l}, 0);
        chk("mid_rst_addr", sdr_addr, 0);
        chk("mid_rst_wdata", sdr_wdata, 0);
        chk("mid_rst_tmo", tmo_err, 0);
        chk("mid_rst_ack", sdram_ack, 0);
        sb.delete();
        tick();
        sdram_reset = 1'b0;
        n_wr = 0;
        n_rd = 0;
        sdr_wr_ack = 1'b1;
        tick();
        sdr_wr_ack = 1'b0;
        repeat (5) tick();
        chk("no_req_after_rst", n_wr + n_rd, 0);
        chk("no_ack_after_rst", sdram_ack, 0);
        sdram_stb = 1'b0;
        tick();
        run_txn(1'b1, 21'h000001, 16'h8001, 2'b00, 4, 16'h0000, 16'h8001, 2'b11, 1'b0, 4, 0);

        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
